lsu_mem_port: RTL

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 95 +++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: CPU load/store port onto a single-port RAM, with read-modify-write for sub-word stores.
// Optional LSU_BACK_TO_BACK_EN lets a new request be accepted in RESP as the response is taken.
module lsu_mem_port #(
    parameter int ADDR_W = 5,
    parameter int D_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [D_BITS-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [D_BITS-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [D_BITS-1:0] ram_din,
    output logic              ram_we,
    input  logic [D_BITS-1:0] ram_dout
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, MERGE, RESP} state_t;
    state_t state, state_nx;
    logic              we_q, uns_q, acc, bad;
    logic [1:0]        size_q, off_q;
    logic [D_BITS-1:0] wdata_q, lane, ext, mask, merged;
    logic [4:0]        sh;
`ifdef LSU_BACK_TO_BACK_EN
    assign req_ready = state == IDLE || (state == RESP && rsp_ready);
`else
    assign req_ready = state == IDLE;
`endif
    assign acc = req_valid && req_ready;
    assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign rsp_valid = state == RESP;
    assign sh = {off_q, 3'b000};
    assign lane = ram_dout >> sh;
    assign ext = size_q == 2'b00 ? {{24{lane[7] & ~uns_q}}, lane[7:0]} :
                 size_q == 2'b01 ? {{16{lane[15] & ~uns_q}}, lane[15:0]} : lane;
    assign mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged = (ram_dout & ~mask) | ((wdata_q << sh) & mask);
    always_comb begin
        state_nx = state;
        case (state)
            ISSUE:   state_nx = (we_q && size_q == 2'b10) ? RESP : CAPT;
            CAPT:    state_nx = we_q ? MERGE : RESP;
            MERGE:   state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = state;
        endcase
        if (acc) state_nx = bad ? RESP : ISSUE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            wdata_q   <= '0;
        end else begin
            state  <= state_nx;
            ram_we <= 1'b0;
            if (acc) begin
                we_q      <= req_we;
                uns_q     <= req_unsigned;
                size_q    <= req_size;
                off_q     <= req_addr[1:0];
                wdata_q   <= req_wdata;
                ram_addr  <= req_addr[ADDR_W+1:2];
                ram_din   <= req_wdata;
                ram_we    <= !bad && req_we && req_size == 2'b10;
                rsp_err   <= bad;
                rsp_rdata <= '0;
            end else if (state == CAPT) begin
                // stores write the merged word back next cycle; loads capture the extended lane
                if (we_q) begin
                    ram_din <= merged;
                    ram_we  <= 1'b1;
                end else begin
                    rsp_rdata <= ext;
                end
            end
        end
    end
endmodule
